micron_sram_responder: RTL and testbench

//  Clocked, synthesizable model of the Micron CellularRAM pins in asynchronous mode: the memory-side

---
 rtl/micron_sram_responder.sv | 174 +++++++++++++++++
 tb/tb_micron_sram_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/micron_sram_responder.sv
// Clocked stand-in for the CellularRAM pins in async mode, answering micron_controller_async traffic.
// Reads return data READ_LAT edges after sampling; writes commit when wr drops; all outputs registered.
module micron_sram_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter int          READ_LAT    = 3,
    parameter logic [15:0] BCR_DEFAULT = 16'h9D1F
) (
    input  logic        clk50MHz,
    input  logic        rst,
    input  logic        mce_L,
    input  logic        moe_L,
    input  logic        mwe_L,
    input  logic        madv_L,
    input  logic        mclk,
    input  logic        mub_L,
    input  logic        mlb_L,
    input  logic        mcre,
    input  logic [22:0] maddr,
    input  logic [15:0] mem_data_in,
    output logic [15:0] mem_data_out,
    output logic        mem_data_oe,
    output logic        mwait,
    output logic [15:0] bcr
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE, CR_WRITE} state_t;

    state_t               state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [22:0]          rd_addr, rd_addr_n;
    logic [ADDR_BITS-1:0] w_addr, w_addr_n;
    logic [15:0]          w_data, w_data_n;
    logic                 w_ub, w_ub_n, w_lb, w_lb_n;
    logic [15:0]          cr_cap, cr_cap_n;
    logic [15:0]          out_n, bcr_n;
    logic                 oe_n, mwait_n;
    logic                 mem_we;
    logic                 start_read, capture;
    logic                 sel, rd, wr, cw;
    logic [15:0]          rd_word;
    logic [15:0]          mem [2**ADDR_BITS];

    logic unused_mclk;
    assign unused_mclk = mclk;

    // Write enable wins over output enable, so rd requires mwe_L high.
    assign sel = !mce_L && !madv_L;
    assign rd  = sel && !moe_L && mwe_L && !mcre;
    assign wr  = sel && !mwe_L && !mcre;
    assign cw  = sel && !mwe_L && mcre;

    assign rd_word = mem[rd_addr[ADDR_BITS-1:0]] & {{8{~mub_L}}, {8{~mlb_L}}};

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rd_addr_n  = rd_addr;
        w_addr_n   = w_addr;
        w_data_n   = w_data;
        w_ub_n     = w_ub;
        w_lb_n     = w_lb;
        cr_cap_n   = cr_cap;
        bcr_n      = bcr;
        out_n      = 16'h0000;
        oe_n       = 1'b0;
        mwait_n    = 1'b0;
        mem_we     = 1'b0;
        start_read = 1'b0;
        capture    = 1'b0;

        case (state)
            IDLE: begin
                if (wr) begin
                    state_n = WR_ACTIVE;
                    capture = 1'b1;
                end else if (cw) begin
                    state_n  = CR_WRITE;
                    cr_cap_n = maddr[15:0];
                end else if (rd) begin
                    start_read = 1'b1;
                end
            end
            RD_WAIT, RD_DRIVE: begin
                if (!rd) begin
                    if (wr) begin
                        state_n = WR_ACTIVE;
                        capture = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (maddr != rd_addr) begin
                    start_read = 1'b1;
                end else if (state == RD_DRIVE || cnt == 4'd0) begin
                    state_n = RD_DRIVE;
                    oe_n    = 1'b1;
                    out_n   = rd_word;
                end else begin
                    cnt_n   = cnt - 4'd1;
                    mwait_n = 1'b1;
                end
            end
            WR_ACTIVE: begin
                if (wr) begin
                    capture = 1'b1;
                end else begin
                    mem_we = 1'b1;
                    if (rd) start_read = 1'b1;
                    else    state_n    = IDLE;
                end
            end
            CR_WRITE: begin
                if (cw) begin
                    cr_cap_n = maddr[15:0];
                end else begin
                    bcr_n   = cr_cap;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (capture) begin
            w_addr_n = maddr[ADDR_BITS-1:0];
            w_data_n = mem_data_in;
            w_ub_n   = ~mub_L;
            w_lb_n   = ~mlb_L;
        end
        if (start_read) begin
            state_n   = RD_WAIT;
            rd_addr_n = maddr;
            cnt_n     = 4'(READ_LAT - 1);
            mwait_n   = 1'b1;
        end
    end

    always_ff @(posedge clk50MHz) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            rd_addr      <= '0;
            w_addr       <= '0;
            w_data       <= 16'h0000;
            w_ub         <= 1'b0;
            w_lb         <= 1'b0;
            cr_cap       <= 16'h0000;
            mem_data_out <= 16'h0000;
            mem_data_oe  <= 1'b0;
            mwait        <= 1'b0;
            bcr          <= BCR_DEFAULT;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rd_addr      <= rd_addr_n;
            w_addr       <= w_addr_n;
            w_data       <= w_data_n;
            w_ub         <= w_ub_n;
            w_lb         <= w_lb_n;
            cr_cap       <= cr_cap_n;
            mem_data_out <= out_n;
            mem_data_oe  <= oe_n;
            mwait        <= mwait_n;
            bcr          <= bcr_n;
        end
    end

    // Array has no reset; a commit pending when rst arrives is simply lost.
    always_ff @(posedge clk50MHz) begin
        if (mem_we && !rst) begin
            if (w_ub) mem[w_addr][15:8] <= w_data[15:8];
            if (w_lb) mem[w_addr][7:0]  <= w_data[7:0];
        end
    end

endmodule

// File: tb/tb_micron_sram_responder.sv
// Randomized plus directed bench for micron_sram_responder against a word-array reference model.
module tb_micron_sram_responder;

    localparam int ADDR_BITS = 10;
    localparam int READ_LAT  = 3;
    localparam int DEPTH     = 1 << ADDR_BITS;

    logic        clk50MHz = 1'b0;
    logic        rst = 1'b1;
    logic        mce_L, moe_L, mwe_L, madv_L, mclk, mub_L, mlb_L, mcre;
    logic [22:0] maddr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        mem_data_oe;
    logic        mwait;
    logic [15:0] bcr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] model [DEPTH];
    bit          known [DEPTH];
    int          pool  [8];

    micron_sram_responder #(.ADDR_BITS(ADDR_BITS), .READ_LAT(READ_LAT), .BCR_DEFAULT(16'h9D1F)) dut (
        .clk50MHz(clk50MHz), .rst(rst), .mce_L(mce_L), .moe_L(moe_L), .mwe_L(mwe_L),
        .madv_L(madv_L), .mclk(mclk), .mub_L(mub_L), .mlb_L(mlb_L), .mcre(mcre),
        .maddr(maddr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_oe(mem_data_oe), .mwait(mwait), .bcr(bcr)
    );

    always #5 clk50MHz = ~clk50MHz;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50MHz);
        #1;
    endtask

    task automatic idle_pins();
        mce_L = 1'b1; madv_L = 1'b1; moe_L = 1'b1; mwe_L = 1'b1;
        mcre = 1'b0; mub_L = 1'b0; mlb_L = 1'b0; mclk = 1'b0;
    endtask

    function automatic int idx_of(input logic [22:0] a);
        return int'(a) % DEPTH;
    endfunction

    function automatic logic [15:0] expect_rd(input logic [22:0] a, input bit ub, input bit lb);
        logic [15:0] mask;
        mask = {{8{ub}}, {8{lb}}};
        return model[idx_of(a)] & mask;
    endfunction

    task automatic set_read(input logic [22:0] a, input bit ub, input bit lb);
        mce_L = 1'b0; madv_L = 1'b0; moe_L = 1'b0; mwe_L = 1'b1; mcre = 1'b0;
        maddr = a; mub_L = !ub; mlb_L = !lb;
    endtask

    task automatic set_write(input logic [22:0] a, input logic [15:0] d, input bit ub, input bit lb,
                             input bit oe_too);
        mce_L = 1'b0; madv_L = 1'b0; mwe_L = 1'b0; moe_L = !oe_too; mcre = 1'b0;
        maddr = a; mem_data_in = d; mub_L = !ub; mlb_L = !lb;
    endtask

    task automatic model_write(input logic [22:0] a, input logic [15:0] d, input bit ub, input bit lb);
        int i;
        i = idx_of(a);
        if (ub) model[i][15:8] = d[15:8];
        if (lb) model[i][7:0]  = d[7:0];
        if (ub && lb) known[i] = 1'b1;
    endtask

    // Called right after the edge that sampled the read request.
    task automatic wait_oe(input string tag, input logic [15:0] exp);
        int n;
        n = 0;
        while (!mem_data_oe && n < 40) begin
            chk({tag, "_mwait"}, 32'(mwait), 32'd1);
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, READ_LAT);
        chk({tag, "_mwait0"}, 32'(mwait), 32'd0);
        chk({tag, "_data"}, 32'(mem_data_out), 32'(exp));
    endtask

    task automatic do_read(input string tag, input logic [22:0] a, input bit ub, input bit lb);
        logic [15:0] exp;
        exp = expect_rd(a, ub, lb);
        set_read(a, ub, lb);
        tick();
        wait_oe(tag, exp);
        tick();
        chk({tag, "_hold"}, 32'(mem_data_out), 32'(exp));
        idle_pins();
        tick();
        chk({tag, "_abort"}, 32'(mem_data_oe), 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [22:0] a, input logic [15:0] d,
                            input bit ub, input bit lb, input int n, input bit oe_too);
        set_write(a, d, ub, lb, oe_too);
        for (int k = 0; k < n; k++) begin
            tick();
            chk({tag, "_oe"}, 32'(mem_data_oe), 32'd0);
        end
        idle_pins();
        tick();
        chk({tag, "_oe_commit"}, 32'(mem_data_oe), 32'd0);
        model_write(a, d, ub, lb);
    endtask

    initial begin
        logic [22:0] a;
        logic [12:0] up;
        logic [15:0] d;
        bit          ub, lb;
        int          sel_op, pi;

        idle_pins();
        maddr = '0;
        mem_data_in = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 16'h0000;
            known[i] = 1'b0;
        end

        tick();
        tick();
        chk("rst_oe", 32'(mem_data_oe), 32'd0);
        chk("rst_out", 32'(mem_data_out), 32'd0);
        chk("rst_mwait", 32'(mwait), 32'd0);
        chk("rst_bcr", 32'(bcr), 32'h9D1F);
        rst = 1'b0;
        tick();

        // Basic write then read with latency check
        do_write("w1", 23'h012, 16'hA5C3, 1, 1, 2, 0);
        do_read("r1", 23'h012, 1, 1);

        // Byte lanes
        do_write("w2a", 23'h020, 16'h1234, 1, 1, 1, 0);
        do_write("w2b", 23'h020, 16'hFFFF, 0, 1, 2, 0);
        do_read("r2a", 23'h020, 1, 1);
        chk("r2a_model", 32'(model[32'h020]), 32'h12FF);
        do_read("r2b", 23'h020, 1, 0);

        // Address change while driving restarts latency
        set_read(23'h012, 1, 1);
        tick();
        wait_oe("r3a", model[32'h012]);
        maddr = 23'h020;
        tick();
        chk("r3_drop", 32'(mem_data_oe), 32'd0);
        wait_oe("r3b", model[32'h020]);
        idle_pins();
        tick();

        // Both enables low: write wins, no drive
        do_write("w4", 23'h005, 16'hBEEF, 1, 1, 2, 1);
        do_read("r4", 23'h005, 1, 1);

        // Write commit straight into a read
        set_write(23'h077, 16'hCAFE, 1, 1, 0);
        tick();
        tick();
        model_write(23'h077, 16'hCAFE, 1, 1);
        set_read(23'h077, 1, 1);
        tick();
        wait_oe("r_chain", 16'hCAFE);
        idle_pins();
        tick();

        // Configuration register write
        do_write("w5", 23'h041, 16'h5A5A, 1, 1, 1, 0);
        mce_L = 1'b0; madv_L = 1'b0; mwe_L = 1'b0; moe_L = 1'b1; mcre = 1'b1;
        maddr = 23'h000041; mem_data_in = 16'h3333;
        tick();
        tick();
        idle_pins();
        tick();
        chk("cr_bcr", 32'(bcr), 32'h0041);
        do_read("r5", 23'h041, 1, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cr_bcr_rst", 32'(bcr), 32'h9D1F);
        tick();

        // Reset in the middle of a write discards it
        do_write("w6a", 23'h030, 16'h0001, 1, 1, 1, 0);
        set_write(23'h030, 16'h7777, 1, 1, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        idle_pins();
        rst = 1'b0;
        tick();
        do_read("r6", 23'h030, 1, 1);
        chk("r6_model", 32'(model[32'h030]), 32'h0001);

        // Aliasing of upper address bits
        do_write("w7", 23'h400, 16'h600D, 1, 1, 1, 0);
        do_read("r7", 23'h000, 1, 1);

        // Randomized traffic over a small address pool with aliased upper bits
        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(DEPTH - 1, 0);
            up = 13'($urandom);
            do_write("wr_init", {up, 10'(pool[i])}, 16'($urandom), 1, 1, 1, 0);
        end
        for (int it = 0; it < 60; it++) begin
            sel_op = $urandom_range(1, 0);
            pi     = $urandom_range(7, 0);
            up     = 13'($urandom);
            a      = {up, 10'(pool[pi])};
            ub     = 1'($urandom);
            lb     = 1'($urandom);
            if (sel_op == 0) begin
                d = 16'($urandom);
                do_write("wr_rand", a, d, ub, lb, $urandom_range(3, 1), 1'($urandom));
            end else if (known[pool[pi]]) begin
                do_read("rd_rand", a, ub, lb);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
